// File: rtl/knapsack_engine_if.sv
// knapsack_engine_if
// Groups the host-facing signals of the knapsack engine.
//   Item loading : item_wr, item_addr, item_wgt, item_val
//   Run control  : item_num, cap, start, busy, done
//   Results      : best_value, overflow
//   Cache read   : rd_addr, rd_data
// The master modport is the host or loader. The slave modport is the engine.
interface knapsack_engine_if #(
   parameter int MAX_CAP  = 64,
   parameter int MAX_ITEM = 16,
   parameter int WGT_W    = 8,
   parameter int VAL_W    = 16
);
   localparam int CAP_W  = $clog2(MAX_CAP);
   localparam int ITEM_W = $clog2(MAX_ITEM);

   logic              item_wr;
   logic [ITEM_W-1:0] item_addr;
   logic [WGT_W-1:0]  item_wgt;
   logic [VAL_W-1:0]  item_val;
   logic [ITEM_W:0]   item_num;
   logic [CAP_W-1:0]  cap;
   logic              start;
   logic              busy;
   logic              done;
   logic [VAL_W-1:0]  best_value;
   logic              overflow;
   logic [CAP_W-1:0]  rd_addr;
   logic [VAL_W-1:0]  rd_data;

   modport master (
      output item_wr, item_addr, item_wgt, item_val, item_num, cap, start, rd_addr,
      input  busy, done, best_value, overflow, rd_data
   );

   modport slave (
      input  item_wr, item_addr, item_wgt, item_val, item_num, cap, start, rd_addr,
      output busy, done, best_value, overflow, rd_data
   );
endinterface

// File: rtl/knapsack_engine.sv
// knapsack_engine
// 0/1 knapsack solver. It holds an item table of weight/value pairs. It runs
// the descending-capacity DP recurrence over a capacity cache, updating one
// cache cell per clock.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high; clears all state, including both tables
//   bus   : slave side of knapsack_engine_if (item load, run control,
//           results, registered cache read port)
module knapsack_engine #(
   parameter int MAX_CAP  = 64,
   parameter int MAX_ITEM = 16,
   parameter int WGT_W    = 8,
   parameter int VAL_W    = 16
) (
   input logic               clk,
   input logic               reset,
   knapsack_engine_if.slave  bus
);
   localparam int CAP_W  = $clog2(MAX_CAP);
   localparam int ITEM_W = $clog2(MAX_ITEM);
   localparam int CMP_W  = (WGT_W > CAP_W) ? WGT_W : CAP_W;

   typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;

   state_t            state_q, state_d;
   logic [CAP_W-1:0]  cap_q, cap_d;
   logic [CAP_W-1:0]  c_q, c_d;
   logic [ITEM_W:0]   n_q, n_d;
   logic [ITEM_W-1:0] k_q, k_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              overflow_q, overflow_d;
   logic [VAL_W-1:0]  best_q, best_d;
   logic [VAL_W-1:0]  rd_data_q, rd_data_d;
   logic [VAL_W-1:0]  cache_q [MAX_CAP];
   logic [VAL_W-1:0]  cache_d [MAX_CAP];
   logic [WGT_W-1:0]  wgt_q [MAX_ITEM];
   logic [WGT_W-1:0]  wgt_d [MAX_ITEM];
   logic [VAL_W-1:0]  val_q [MAX_ITEM];
   logic [VAL_W-1:0]  val_d [MAX_ITEM];

   logic [WGT_W-1:0]  cur_w;
   logic [VAL_W-1:0]  cur_v;
   logic              fits;
   logic [CAP_W-1:0]  src_idx;
   logic [VAL_W:0]    sum;
   logic [VAL_W-1:0]  sat;
   logic              enter_done;

   // Candidate for cell c with item k. src_idx is only meaningful when the
   // item fits. Then w <= c < MAX_CAP, so the low bits of w are enough.
   assign cur_w   = wgt_q[k_q];
   assign cur_v   = val_q[k_q];
   assign fits    = CMP_W'(c_q) >= CMP_W'(cur_w);
   assign src_idx = c_q - cur_w[CAP_W-1:0];
   assign sum     = {1'b0, cache_q[src_idx]} + {1'b0, cur_v};
   assign sat     = sum[VAL_W] ? {VAL_W{1'b1}} : sum[VAL_W-1:0];

   // Next-state logic and datapath for the controller.
   // The read port samples the current cache contents in every state.
   // best_value is taken from the post-update cache. That covers cap=0,
   // where the last SCAN write lands on cache[cap].
   always_comb begin
      state_d    = state_q;
      cap_d      = cap_q;
      c_d        = c_q;
      n_d        = n_q;
      k_d        = k_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      overflow_d = overflow_q;
      best_d     = best_q;
      cache_d    = cache_q;
      wgt_d      = wgt_q;
      val_d      = val_q;
      enter_done = 1'b0;
      rd_data_d  = cache_q[bus.rd_addr];

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cap_d      = bus.cap;
               c_d        = bus.cap;
               n_d        = (bus.item_num > (ITEM_W+1)'(MAX_ITEM)) ? (ITEM_W+1)'(MAX_ITEM) : bus.item_num;
               overflow_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = CLEAR;
            end else if (bus.item_wr) begin
               wgt_d[bus.item_addr] = bus.item_wgt;
               val_d[bus.item_addr] = bus.item_val;
            end
         end
         CLEAR: begin
            cache_d[c_q] = '0;
            c_d          = c_q - 1'b1;
            if (c_q == '0) begin
               c_d = cap_q;
               k_d = '0;
               if (n_q == '0) begin
                  state_d    = DONE;
                  enter_done = 1'b1;
               end else begin
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            if (fits) begin
               if (sat > cache_q[c_q]) begin
                  cache_d[c_q] = sat;
               end
               if (sum[VAL_W]) begin
                  overflow_d = 1'b1;
               end
            end
            c_d = c_q - 1'b1;
            if (c_q == '0) begin
               c_d = cap_q;
               k_d = k_q + 1'b1;
               if ({1'b0, k_q} == (n_q - 1'b1)) begin
                  state_d    = DONE;
                  enter_done = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (enter_done) begin
         busy_d = 1'b0;
         done_d = 1'b1;
         best_d = cache_d[cap_q];
      end
   end

   // State register. Reset clears everything, including the item table and cache.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cap_q      <= '0;
         c_q        <= '0;
         n_q        <= '0;
         k_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         best_q     <= '0;
         rd_data_q  <= '0;
         for (int i = 0; i < MAX_CAP; i++) begin
            cache_q[i] <= '0;
         end
         for (int i = 0; i < MAX_ITEM; i++) begin
            wgt_q[i] <= '0;
            val_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         cap_q      <= cap_d;
         c_q        <= c_d;
         n_q        <= n_d;
         k_q        <= k_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
         best_q     <= best_d;
         rd_data_q  <= rd_data_d;
         cache_q    <= cache_d;
         wgt_q      <= wgt_d;
         val_q      <= val_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.best_value = best_q;
   assign bus.overflow   = overflow_q;
   assign bus.rd_data    = rd_data_q;
endmodule

// File: tb/tb_knapsack_engine.sv
// tb_knapsack_engine
// Drives knapsack_engine through directed and randomized runs. Expected
// results come from a brute-force subset search over the bench's own copy
// of the item table.
module tb_knapsack_engine;
   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   edgeCount;
   int   e0;
   int   modW [16];
   int   modV [16];

   knapsack_engine_if bus();

   knapsack_engine dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts rising edges so that run latencies can be measured in edges.
   initial edgeCount = 0;
   always @(posedge clk) edgeCount <= edgeCount + 1;

   // Best saturated value over every subset of the first kLim items whose total weight fits in c.
   function automatic int bestFor(int kLim, int c);
      int best;
      int ws;
      int vs;
      best = 0;
      for (int m = 0; m < (1 << kLim); m++) begin
         ws = 0;
         vs = 0;
         for (int i = 0; i < kLim; i++) begin
            if (m[i]) begin
               ws += modW[i];
               vs += modV[i];
            end
         end
         if (vs > 65535) vs = 65535;
         if (ws <= c && vs > best) best = vs;
      end
      return best;
   endfunction

   // Overflow occurs when any fitting candidate, built from the best result of the earlier items, exceeds 16 bits.
   function automatic int modelOverflow(int n, int cap);
      for (int k = 0; k < n; k++) begin
         for (int c = modW[k]; c <= cap; c++) begin
            if (bestFor(k, c - modW[k]) + modV[k] > 65535) return 1;
         end
      end
      return 0;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic writeItem(input int a, input int w, input int v);
      @(negedge clk);
      bus.item_wr   = 1'b1;
      bus.item_addr = 4'(a);
      bus.item_wgt  = 8'(w);
      bus.item_val  = 16'(v);
      @(negedge clk);
      bus.item_wr = 1'b0;
      modW[a] = w;
      modV[a] = v;
   endtask

   task automatic loadBaseline();
      writeItem(0, 2, 12);
      writeItem(1, 1, 10);
      writeItem(2, 3, 20);
      writeItem(3, 2, 15);
      writeItem(4, 1, 8);
   endtask

   // Start is sampled at the edge after this negedge (E0). busy must be up by the next negedge.
   task automatic applyStimulus(input int num, input int c);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.cap      = 6'(c);
      bus.item_num = 5'(num);
      e0 = edgeCount + 1;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("busyAfterStart", 32'(bus.busy), 1);
   endtask

   task automatic waitDone(input string tag, output int lat);
      lat = -1;
      for (int i = 0; i < 3000; i++) begin
         if (bus.done) begin
            lat = edgeCount - e0;
            break;
         end
         @(negedge clk);
      end
      if (lat < 0) checkOutput({tag, "_timeout"}, 0, 1);
   endtask

   task automatic checkRun(input string tag, input int num, input int c, input bit sweep);
      int n;
      int lat;
      n = (num > 16) ? 16 : num;
      waitDone(tag, lat);
      if (lat >= 0) begin
         checkOutput({tag, "_latency"}, lat, (c + 1) * (n + 1));
         checkOutput({tag, "_busyLow"}, 32'(bus.busy), 0);
         checkOutput({tag, "_best"}, 32'(bus.best_value), bestFor(n, c));
         checkOutput({tag, "_overflow"}, 32'(bus.overflow), modelOverflow(n, c));
         @(negedge clk);
         checkOutput({tag, "_donePulse"}, 32'(bus.done), 0);
         if (sweep) begin
            for (int i = 0; i <= c; i++) begin
               bus.rd_addr = 6'(i);
               @(negedge clk);
               checkOutput({tag, "_cache"}, 32'(bus.rd_data), bestFor(n, i));
            end
         end
      end
   endtask

   initial begin
      int lat;
      int rn;
      int rc;
      total = 0;
      bad   = 0;
      for (int i = 0; i < 16; i++) begin
         modW[i] = 0;
         modV[i] = 0;
      end
      reset         = 1'b1;
      bus.item_wr   = 1'b0;
      bus.item_addr = '0;
      bus.item_wgt  = '0;
      bus.item_val  = '0;
      bus.item_num  = '0;
      bus.cap       = '0;
      bus.start     = 1'b0;
      bus.rd_addr   = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rstBusy", 32'(bus.busy), 0);
      checkOutput("rstDone", 32'(bus.done), 0);
      checkOutput("rstBest", 32'(bus.best_value), 0);
      checkOutput("rstOvf", 32'(bus.overflow), 0);
      checkOutput("rstRd", 32'(bus.rd_data), 0);

      $display("[TB] baseline run");
      loadBaseline();
      applyStimulus(5, 5);
      checkRun("baseline", 5, 5, 1'b1);
      checkOutput("baselineBest38", 32'(bus.best_value), 38);

      $display("[TB] start and item_wr ignored while busy");
      applyStimulus(5, 5);
      repeat (10) @(negedge clk);
      bus.start     = 1'b1;
      bus.item_wr   = 1'b1;
      bus.item_addr = 4'd0;
      bus.item_wgt  = 8'd1;
      bus.item_val  = 16'd99;
      bus.cap       = 6'd3;
      bus.item_num  = 5'd1;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.item_wr = 1'b0;
      checkRun("ignored", 5, 5, 1'b0);
      applyStimulus(5, 5);
      checkRun("ignoredRerun", 5, 5, 1'b0);

      $display("[TB] saturation");
      writeItem(0, 1, 40000);
      writeItem(1, 1, 40000);
      applyStimulus(2, 2);
      checkRun("saturate", 2, 2, 1'b1);
      checkOutput("saturateOvfSet", 32'(bus.overflow), 1);
      loadBaseline();
      applyStimulus(5, 5);
      checkRun("cleanAfterSat", 5, 5, 1'b0);

      $display("[TB] degenerate items");
      applyStimulus(0, 7);
      checkRun("noItems", 0, 7, 1'b0);
      writeItem(0, 9, 5);
      applyStimulus(1, 7);
      checkRun("tooHeavy", 1, 7, 1'b0);
      writeItem(0, 0, 5);
      applyStimulus(1, 7);
      checkRun("zeroWeight", 1, 7, 1'b1);
      applyStimulus(1, 0);
      checkRun("capZero", 1, 0, 1'b1);

      $display("[TB] randomized runs");
      for (int r = 0; r < 5; r++) begin
         rn = $urandom_range(1, 7);
         rc = $urandom_range(0, 20);
         for (int i = 0; i < rn; i++) begin
            if ($urandom_range(0, 3) == 0) writeItem(i, $urandom_range(0, 12), $urandom_range(30000, 65535));
            else writeItem(i, $urandom_range(0, 12), $urandom_range(0, 1000));
         end
         applyStimulus(rn, rc);
         checkRun("random", rn, rc, 1'b1);
      end

      $display("[TB] reset mid-run");
      loadBaseline();
      applyStimulus(5, 5);
      checkRun("preReset", 5, 5, 1'b0);
      bus.rd_addr = 6'd1;
      applyStimulus(5, 5);
      while (edgeCount < e0 + 20) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("midRstBusy", 32'(bus.busy), 0);
      checkOutput("midRstBest", 32'(bus.best_value), 0);
      checkOutput("midRstRd", 32'(bus.rd_data), 0);
      checkOutput("midRstDone", 32'(bus.done), 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         modW[i] = 0;
         modV[i] = 0;
      end
      applyStimulus(5, 5);
      checkRun("afterReset", 5, 5, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
